mem_stage_ls: RTL and testbench

Parametrised memory-access stage for the MIPS pipeline: a multi-cycle load/store unit wrapping a byte-lane data memory. It supports byte, halfword and word accesses with sign/zero extension, detects misaligned accesses, and models a configurable number of memory wait states. During wait states it raises a stall towards the hazard unit. It sits between the EX/MEM and MEM/WB pipeline registers and replaces the single-cycle word-only data memory path.

---
 rtl/mem_stage_ls.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_ls.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ls.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ls
// Description : Multi-cycle load/store unit for the MIPS MEM stage. Wraps a
//               little-endian byte-lane data memory and supports byte, half
//               and word accesses with sign/zero extension. Misaligned
//               accesses are flagged and do not touch memory. A configurable
//               number of wait states is modelled, with a stall raised
//               towards the hazard unit while the access is in flight.
// Ports       : i_clock, i_reset          clock, async active-high reset
//               i_valid, i_memread,        request qualifiers (store wins
//               i_memwrite                 when both read and write are set)
//               i_size, i_unsigned         access size / load extension
//               i_address, i_datawrite     byte address / right-aligned data
//               o_dataread                 extended load result (held)
//               o_done, o_misaligned       completion pulse / fault flag
//               o_stall                    upstream freeze request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ls #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_memread,
    input  logic                  i_memwrite,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_datawrite,
    output logic [DATA_WIDTH-1:0] o_dataread,
    output logic                  o_done,
    output logic                  o_misaligned,
    output logic                  o_stall
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_count;
    logic [ADDR_WIDTH+1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic                    r_op_write;
    logic [DATA_WIDTH-1:0]   r_dataread;
    logic                    r_done;
    logic                    r_mis;
    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [1:0]              w_lane;
    logic                    w_mis;
    logic                    w_commit;
    logic                    w_request;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [3:0]              w_be;
    logic [DATA_WIDTH-1:0]   w_lane_data;
    logic                    w_unused_addr;

    // Upper address bits are deliberately ignored: the address wraps.
    assign w_unused_addr = ^i_address[DATA_WIDTH-1:ADDR_WIDTH+2];

    assign w_idx     = r_addr[ADDR_WIDTH+1:2];
    assign w_lane    = r_addr[1:0];
    assign w_request = i_valid && (i_memread || i_memwrite);
    assign w_commit  = (r_state == ST_ACCESS) && (r_count == 4'd0);
    assign w_word    = r_mem[w_idx];

    // Size 2'b11 behaves exactly like a word access.
    always_comb begin
        w_mis = 1'b0;
        case (r_size)
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = r_addr[0];
            default: w_mis = |r_addr[1:0];
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        w_byte = w_word[{w_lane, 3'b000} +: 8];
        w_half = w_word[{w_lane[1], 4'b0000} +: 16];
        w_load = w_word;
        case (r_size)
            2'b00:   w_load = r_uns ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                    : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                    : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Store data is replicated across lanes; the enables pick the live ones.
    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = r_wdata;
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_lane_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_lane_data = r_wdata;
            end
        endcase
    end

    // Memory array has no reset: contents survive a pipeline reset.
    always_ff @(posedge i_clock) begin
        if (w_commit && r_op_write && !w_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_op_write <= 1'b0;
            r_dataread <= '0;
            r_done     <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_mis  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_addr     <= i_address[ADDR_WIDTH+1:0];
                        r_wdata    <= i_datawrite;
                        r_size     <= i_size;
                        r_uns      <= i_unsigned;
                        r_op_write <= i_memwrite;
                        r_count    <= 4'(WAIT_STATES);
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_count == 4'd0) begin
                        r_state <= ST_RESP;
                        r_done  <= 1'b1;
                        r_mis   <= w_mis;
                        // A misaligned access of either kind reports zero.
                        if (w_mis) begin
                            r_dataread <= '0;
                        end else if (!r_op_write) begin
                            r_dataread <= w_load;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_RESP: begin
                    // No accept here: the held request must not be re-taken.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_dataread   = r_dataread;
    assign o_done       = r_done;
    assign o_misaligned = r_mis;
    assign o_stall      = ((r_state == ST_IDLE) && w_request) || (r_state == ST_ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ls.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ls
// Description : Self-checking bench for mem_stage_ls. Two instances are
//               used, one with two wait states and one with none. Expected
//               results come from a byte-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ls;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid [2];
    logic        rd    [2];
    logic        wr    [2];
    logic        uns   [2];
    logic [1:0]  size  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] dread [2];
    logic        done  [2];
    logic        mis   [2];
    logic        stall [2];

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mbytes    [2][1024];
    logic [31:0] exp_dread [2];

    always #5 clk = ~clk;

    mem_stage_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(2)) u_dut_ws2 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[0]), .i_memread(rd[0]),
        .i_memwrite(wr[0]), .i_size(size[0]), .i_unsigned(uns[0]),
        .i_address(addr[0]), .i_datawrite(wdata[0]), .o_dataread(dread[0]),
        .o_done(done[0]), .o_misaligned(mis[0]), .o_stall(stall[0])
    );

    mem_stage_ls #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut_ws0 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid[1]), .i_memread(rd[1]),
        .i_memwrite(wr[1]), .i_size(size[1]), .i_unsigned(uns[1]),
        .i_address(addr[1]), .i_datawrite(wdata[1]), .o_dataread(dread[1]),
        .o_done(done[1]), .o_misaligned(mis[1]), .o_stall(stall[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Little-endian gather from the byte model, then extend arithmetically.
    function automatic logic [31:0] model_load(input int sel, input logic [31:0] a,
                                               input int n, input bit u);
        longint v;
        int     base;
        v    = 0;
        base = int'(a[9:0]);
        for (int i = 0; i < n; i++) begin
            v = v | (longint'(mbytes[sel][base + i]) << (8 * i));
        end
        if (!u && n < 4 && v[8*n-1]) begin
            v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic idle_inputs(input int sel);
        valid[sel] = 1'b0;
        rd[sel]    = 1'b0;
        wr[sel]    = 1'b0;
        uns[sel]   = 1'b0;
        size[sel]  = 2'b00;
        addr[sel]  = '0;
        wdata[sel] = '0;
    endtask

    // One full transaction: request in IDLE, held until RESP, then dropped.
    task automatic access(input int sel, input bit w, input bit r, input logic [1:0] sz,
                          input bit u, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
        int n;
        int ws;
        int k;
        bit emis;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ws   = (sel == 0) ? 2 : 0;
        emis = (int'(a[1:0]) % n) != 0;
        if (emis) begin
            exp_dread[sel] = '0;
        end else if (w) begin
            for (int i = 0; i < n; i++) begin
                mbytes[sel][int'(a[9:0]) + i] = 8'((d >> (8 * i)) & 32'hFF);
            end
        end else begin
            exp_dread[sel] = model_load(sel, a, n, u);
        end

        @(negedge clk);
        valid[sel] = 1'b1;
        rd[sel]    = r;
        wr[sel]    = w;
        size[sel]  = sz;
        uns[sel]   = u;
        addr[sel]  = a;
        wdata[sel] = d;
        #1;
        check({tag, "_stall_req"}, 32'(stall[sel]), 32'd1);

        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (done[sel]) break;
            check({tag, "_stall_busy"}, 32'(stall[sel]), 32'd1);
            if (k > 40) begin
                tests++;
                fails++;
                $error("FAIL %s_timeout: observed no done expected done by cycle %0d", tag, ws + 2);
                break;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(ws + 2));
        check({tag, "_stall_resp"}, 32'(stall[sel]), 32'd0);
        check({tag, "_misaligned"}, 32'(mis[sel]), 32'(emis));
        check({tag, "_dataread"}, dread[sel], exp_dread[sel]);
        idle_inputs(sel);
    endtask

    initial begin
        idle_inputs(0);
        idle_inputs(1);
        exp_dread[0] = '0;
        exp_dread[1] = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 1024; i++) mbytes[s][i] = 8'h00;
        end

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_dataread", dread[s], 32'h0);
            check("reset_done", 32'(done[s]), 32'd0);
            check("reset_mis", 32'(mis[s]), 32'd0);
            check("reset_stall", 32'(stall[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Known contents for every word of the two-wait-state instance.
        for (int i = 0; i < 256; i++) begin
            access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), $urandom, "prefill");
        end

        access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "st_word");
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, "ld_word");
        check("ld_word_const", dread[0], 32'hDEADBEEF);

        access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0000_0080, "st_byte");
        access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0, "ld_sbyte");
        check("ld_sbyte_const", dread[0], 32'hFFFFFF80);
        access(0, 1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'h0, "ld_ubyte");
        check("ld_ubyte_const", dread[0], 32'h00000080);
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, "ld_word2");
        check("ld_word2_const", dread[0], 32'h80ADBEEF);

        access(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0000_8001, "st_half");
        access(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0, "ld_shalf");
        check("ld_shalf_const", dread[0], 32'hFFFF8001);
        access(0, 1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h0, "ld_uhalf");
        check("ld_uhalf_const", dread[0], 32'h00008001);

        access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, "st_w40");
        access(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h0, "mis_half");
        check("mis_half_const", dread[0], 32'h0);
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, "ld_w40a");
        access(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h42, 32'hFFFFFFFF, "mis_word_st");
        check("mis_word_st_const", dread[0], 32'h0);
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, "ld_w40b");
        check("ld_w40b_const", dread[0], 32'h0BADF00D);

        // Valid without an operation must not be accepted.
        @(negedge clk);
        valid[0] = 1'b1;
        #1 check("noop_stall", 32'(stall[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("noop_done", 32'(done[0]), 32'd0);
        end
        idle_inputs(0);

        // Address wrap on both wait-state settings.
        access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h12345678, "wrap_st");
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 32'h0, "wrap_ld");
        check("wrap_ld_const", dread[0], 32'h12345678);
        access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h12345678, "ws0_wrap_st");
        access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 32'h0, "ws0_wrap_ld");
        check("ws0_wrap_ld_const", dread[1], 32'h12345678);

        // Reset during the first ACCESS cycle of a store discards it.
        @(negedge clk);
        valid[0] = 1'b1;
        wr[0]    = 1'b1;
        size[0]  = 2'b10;
        addr[0]  = 32'h80;
        wdata[0] = 32'hAAAAAAAA;
        @(negedge clk);
        idle_inputs(0);
        rst = 1'b1;
        exp_dread[0] = '0;
        exp_dread[1] = '0;
        #1;
        check("rst_mid_dataread", dread[0], 32'h0);
        check("rst_mid_done", 32'(done[0]), 32'd0);
        check("rst_mid_mis", 32'(mis[0]), 32'd0);
        check("rst_mid_stall", 32'(stall[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("rst_mid_no_done", 32'(done[0]), 32'd0);
        end
        access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0, "rst_mid_ld");

        // Randomised traffic against the byte model.
        for (int t = 0; t < 80; t++) begin
            bit w;
            bit r;
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            access(0, w, r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
